// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic feeder slice.
//   - default element width / mesh dimension / buffer depth
//   - feeder FSM state encoding
//   - lane vector typedefs for the default configuration
//   - counter width helper (bits needed to hold 0..n-1)
package systolic_pkg;

  localparam int DIN_WIDTH_DEF = 8;
  localparam int N_DEF         = 4;
  localparam int M_MAX_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } feeder_state_e;

  typedef logic [N_DEF-1:0][DIN_WIDTH_DEF-1:0]   lane_vec_t;
  typedef logic [N_DEF-1:0][2*DIN_WIDTH_DEF-1:0] psum_vec_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int KCNT_W = cnt_w(M_MAX_DEF);
  localparam int TCNT_W = cnt_w(M_MAX_DEF + N_DEF - 1);

endpackage

// File: rtl/systolic_feeder_if.sv
// Operand source stream into the feeder: one A/B k-slice per beat.
//   s_a     A k-slice, s_a[l] = A[l][k]
//   s_b     B k-slice, s_b[l] = B[k][l]
//   s_valid beat valid (source)
//   s_last  final slice of the operand set (source)
//   s_ready feeder can accept a beat
// master = operand source, slave = feeder.
interface systolic_feeder_if #(
  parameter int DIN_WIDTH = 8,
  parameter int N         = 4
);
  logic [N-1:0][DIN_WIDTH-1:0] s_a;
  logic [N-1:0][DIN_WIDTH-1:0] s_b;
  logic                        s_valid;
  logic                        s_last;
  logic                        s_ready;

  modport master (
    output s_a, s_b, s_valid, s_last,
    input  s_ready
  );

  modport slave (
    input  s_a, s_b, s_valid, s_last,
    output s_ready
  );
endinterface

// File: rtl/systolic_feeder_lane_skew.sv
// One output lane of the feeder wavefront.
//   stream  feeder is in STREAM
//   t_cnt   current stream step
//   m       number of buffered k-slices
//   col_a   buffered A values for this lane, indexed by k
//   col_b   buffered B values for this lane, indexed by k
//   a_lane  A value driven to the array on this lane (zero padded)
//   b_lane  B value driven to the array on this lane (zero padded)
// Lane LANE is delayed by LANE steps: at step t it shows slice k = t - LANE,
// or zero when that slice does not exist.
module feeder_lane_skew
  import systolic_pkg::*;
#(
  parameter int DIN_WIDTH = DIN_WIDTH_DEF,
  parameter int M_MAX     = M_MAX_DEF,
  parameter int LANE      = 0,
  parameter int KW        = KCNT_W,
  parameter int MW        = cnt_w(M_MAX_DEF + 1),
  parameter int TW        = TCNT_W
) (
  input  logic                              stream,
  input  logic [TW-1:0]                     t_cnt,
  input  logic [MW-1:0]                     m,
  input  logic [M_MAX-1:0][DIN_WIDTH-1:0]   col_a,
  input  logic [M_MAX-1:0][DIN_WIDTH-1:0]   col_b,
  output logic [DIN_WIDTH-1:0]              a_lane,
  output logic [DIN_WIDTH-1:0]              b_lane
);

  // One extra bit so t - LANE never aliases and m always fits.
  localparam int XW = ((TW + 1) > MW) ? (TW + 1) : MW;

  logic [XW-1:0] k_ext;
  logic          in_range;

  always_comb begin
    k_ext    = XW'(t_cnt) - XW'(LANE);
    in_range = stream && (XW'(t_cnt) >= XW'(LANE)) && (k_ext < XW'(m));
    a_lane   = '0;
    b_lane   = '0;
    if (in_range) begin
      a_lane = col_a[k_ext[KW-1:0]];
      b_lane = col_b[k_ext[KW-1:0]];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Transmit side of the systolic array input: buffers one operand set of
// M k-slices, then replays it as a skewed diagonal wavefront.
//   clk, rst_n  clock, asynchronous active-low reset
//   src         operand source stream (slave side)
//   a_din       skewed A lanes to the mesh
//   b_din       skewed B lanes to the mesh
//   c_din       partial-sum seed, always zero
//   in_valid    stream step valid (every STREAM cycle)
//   in_last     final stream step, t = M+N-2
//   busy        FSM not idle
//   overflow    one-cycle pulse when the set was cut at M_MAX slices
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DIN_WIDTH = DIN_WIDTH_DEF,
  parameter int N         = N_DEF,
  parameter int M_MAX     = M_MAX_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  systolic_feeder_if.slave                  src,
  output logic [N-1:0][DIN_WIDTH-1:0]       a_din,
  output logic [N-1:0][DIN_WIDTH-1:0]       b_din,
  output logic [N-1:0][2*DIN_WIDTH-1:0]     c_din,
  output logic                              in_valid,
  output logic                              in_last,
  output logic                              busy,
  output logic                              overflow
);

  localparam int KW = cnt_w(M_MAX);
  localparam int MW = cnt_w(M_MAX + 1);
  localparam int TW = cnt_w(M_MAX + N - 1);

  localparam logic [KW-1:0] K_END = KW'(M_MAX - 1);
  localparam logic [TW-1:0] T_PAD = TW'(N - 2);

  feeder_state_e state_q, state_d;
  logic [KW-1:0] k_cnt_q, k_cnt_d;
  logic [TW-1:0] t_cnt_q, t_cnt_d;
  logic [MW-1:0] m_q, m_d;
  logic          overflow_q, overflow_d;

  logic          s_ready;
  logic          accept;
  logic          t_end;
  logic          streaming;

  // Operand buffers: written only on accepted beats, contents are don't-care
  // after reset, so they carry no reset.
  logic [M_MAX-1:0][N-1:0][DIN_WIDTH-1:0] buf_a_q;
  logic [M_MAX-1:0][N-1:0][DIN_WIDTH-1:0] buf_b_q;

  assign s_ready     = (state_q != STREAM);
  assign src.s_ready = s_ready;
  assign accept      = src.s_valid & s_ready;
  assign streaming   = (state_q == STREAM);
  assign t_end       = (t_cnt_q == (TW'(m_q) + T_PAD));

  always_comb begin
    state_d    = state_q;
    k_cnt_d    = k_cnt_q;
    t_cnt_d    = t_cnt_q;
    m_d        = m_q;
    overflow_d = 1'b0;

    case (state_q)
      // IDLE shares the load path: k_cnt is zero there, so the first beat
      // lands in slot 0 and the M_MAX cut-off applies uniformly.
      IDLE, LOAD: begin
        if (accept) begin
          k_cnt_d = k_cnt_q + KW'(1);
          state_d = LOAD;
          if (src.s_last || (k_cnt_q == K_END)) begin
            state_d    = STREAM;
            m_d        = MW'(k_cnt_q) + MW'(1);
            t_cnt_d    = '0;
            overflow_d = !src.s_last;
          end
        end
      end

      STREAM: begin
        t_cnt_d = t_cnt_q + TW'(1);
        if (t_end) begin
          state_d = IDLE;
          k_cnt_d = '0;
          t_cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        k_cnt_d = '0;
        t_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_cnt_q    <= '0;
      t_cnt_q    <= '0;
      m_q        <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_cnt_q    <= k_cnt_d;
      t_cnt_q    <= t_cnt_d;
      m_q        <= m_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_a_q[k_cnt_q] <= src.s_a;
      buf_b_q[k_cnt_q] <= src.s_b;
    end
  end

  // Outputs decode registered state directly, so an asynchronous reset
  // clears them without waiting for a clock edge.
  assign in_valid = streaming;
  assign in_last  = streaming & t_end;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;
  assign c_din    = '0;

  for (genvar l = 0; l < N; l++) begin : g_lane
    logic [M_MAX-1:0][DIN_WIDTH-1:0] col_a;
    logic [M_MAX-1:0][DIN_WIDTH-1:0] col_b;

    for (genvar k = 0; k < M_MAX; k++) begin : g_col
      assign col_a[k] = buf_a_q[k][l];
      assign col_b[k] = buf_b_q[k][l];
    end

    feeder_lane_skew #(
      .DIN_WIDTH (DIN_WIDTH),
      .M_MAX     (M_MAX),
      .LANE      (l),
      .KW        (KW),
      .MW        (MW),
      .TW        (TW)
    ) u_skew (
      .stream (streaming),
      .t_cnt  (t_cnt_q),
      .m      (m_q),
      .col_a  (col_a),
      .col_b  (col_b),
      .a_lane (a_din[l]),
      .b_lane (b_din[l])
    );
  end

endmodule
